// File: rtl/pspwm_pkg.sv
// Shared constants and helpers for the phase-shifted PWM core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pspwm_pkg;

  // Cycles from carrier count to gate outputs: compare register + dead-time register.
  localparam int LAT       = 2;
  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;

  // Channel-local count: (cnt + ph) mod p, valid for cnt < p and ph < p.
  // The sum is carried 32 bits wide so it can never overflow for counter widths up to 31.
  function automatic logic [31:0] phase_wrap(input logic [31:0] cnt,
                                             input logic [31:0] ph,
                                             input logic [31:0] p);
    logic [31:0] s;
    s = cnt + ph;
    return (s >= p) ? (s - p) : s;
  endfunction

endpackage

// File: rtl/pspwm_deadtime.sv
// Dead-time inserter for one channel: turns the ideal PWM level into non-overlapping
// high/low gate drives. Latency: 1 cycle. Backpressure: none (free-running stream).
// Ports: clk_i/rst_i clock and async active-high reset; clr_i synchronously forces both
// gates low; ideal_i ideal PWM level; dt_i dead-time in cycles; pwm_h_o/pwm_l_o gate drives.
module pspwm_deadtime
  import pspwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            ideal_i,
  input  logic [DT_W-1:0] dt_i,
  output logic            pwm_h_o,
  output logic            pwm_l_o
);

  localparam logic [DT_W-1:0] AGE_MAX = '1;

  logic            prev_q;
  logic [DT_W-1:0] age_q;
  logic [DT_W-1:0] age_d;
  logic            h_q;
  logic            l_q;

  // age = cycles the ideal level has held its current value (0 on the change cycle),
  // saturating so long steady states never wrap back into the dead band.
  always_comb begin
    age_d = '0;
    if (ideal_i == prev_q) begin
      age_d = (age_q == AGE_MAX) ? AGE_MAX : age_q + DT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      age_q  <= '0;
      h_q    <= 1'b0;
      l_q    <= 1'b0;
    end else if (clr_i) begin
      // While stopped both gates are off, so the channel counts as having been low
      // forever: a restart that begins low may drive the low side straight away.
      prev_q <= 1'b0;
      age_q  <= AGE_MAX;
      h_q    <= 1'b0;
      l_q    <= 1'b0;
    end else begin
      prev_q <= ideal_i;
      age_q  <= age_d;
      h_q    <= ideal_i && (age_d >= dt_i);
      l_q    <= !ideal_i && (age_d >= dt_i);
    end
  end

  assign pwm_h_o = h_q;
  assign pwm_l_o = l_q;

endmodule

// File: rtl/pspwm_multich_core.sv
// N-channel phase-shifted PWM: shared carrier, per-channel duty/phase, dead-time gates.
// Latency: LAT=2 cycles from carrier count to pwm_h/pwm_l/sync_out; load_ack same cycle as copy.
// Backpressure: load_req is a request held pending until the period boundary; load_ack closes it.
// Ports: ACLK/ARESET clock and async active-high reset; enable runs the carrier;
// period/duty/phase/deadtime shadow inputs; load_req/load_ack reload handshake;
// pwm_h/pwm_l complementary gates; sync_out marks carrier count 0 at the outputs.
module pspwm_multich_core
  import pspwm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [N_CH*CNT_W-1:0] phase,
  input  logic [DT_W-1:0]       deadtime,
  input  logic                  load_req,
  output logic                  load_ack,
  output logic [N_CH-1:0]       pwm_h,
  output logic [N_CH-1:0]       pwm_l,
  output logic                  sync_out
);

  // Active set, loaded only at a period boundary (or while stopped) so a reload never
  // produces a truncated or stretched pulse.
  logic [CNT_W-1:0]      per_q;
  logic [N_CH*CNT_W-1:0] duty_q;
  logic [N_CH*CNT_W-1:0] phase_q;
  logic [DT_W-1:0]       dt_q;
  logic                  pend_q, pend_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_CH-1:0]       ideal_q, ideal_d;
  logic                  sync1_q, sync_q;

  logic             running;
  logic             wrap;
  logic             copy;
  logic [CNT_W-1:0] per_m1;

  assign per_m1   = per_q - CNT_W'(1);
  assign running  = enable && (per_q >= CNT_W'(2));
  assign wrap     = running && (cnt_q == per_m1);
  assign copy     = pend_q && (wrap || !running);
  assign load_ack = copy;

  always_comb begin
    cnt_d = '0;
    if (running && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A request arriving on the copy cycle is satisfied by that same copy.
    pend_d = copy ? 1'b0 : (pend_q || load_req);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q   <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      phase_q <= '0;
      dt_q    <= '0;
      pend_q  <= 1'b0;
      ideal_q <= '0;
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ideal_q <= ideal_d;
      sync1_q <= running && (cnt_q == '0);
      sync_q  <= sync1_q && running;
      if (copy) begin
        per_q   <= period;
        duty_q  <= duty;
        phase_q <= phase;
        dt_q    <= deadtime;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] ph_raw;
    logic [CNT_W-1:0] ph;
    logic [CNT_W-1:0] ch_cnt;

    assign ph_raw = phase_q[g*CNT_W +: CNT_W];
    // Offsets beyond the period clamp to the last carrier slot.
    assign ph     = (ph_raw > per_m1) ? per_m1 : ph_raw;
    assign ch_cnt = CNT_W'(phase_wrap(32'(cnt_q), 32'(ph), 32'(per_q)));
    assign ideal_d[g] = running && (ch_cnt < duty_q[g*CNT_W +: CNT_W]);

    pspwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk_i   (ACLK),
      .rst_i   (ARESET),
      .clr_i   (!running),
      .ideal_i (ideal_q[g]),
      .dt_i    (dt_q),
      .pwm_h_o (pwm_h[g]),
      .pwm_l_o (pwm_l[g])
    );
  end

  assign sync_out = sync_q;

endmodule

// File: tb/tb_pspwm_multich_core.sv
module tb_pspwm_multich_core;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int DT_W  = 8;
  localparam int MAXC  = 16384;

  logic                  ACLK = 1'b0;
  logic                  ARESET;
  logic                  enable;
  logic [CNT_W-1:0]      period;
  logic [N_CH*CNT_W-1:0] duty;
  logic [N_CH*CNT_W-1:0] phase;
  logic [DT_W-1:0]       deadtime;
  logic                  load_req;
  logic                  load_ack;
  logic [N_CH-1:0]       pwm_h;
  logic [N_CH-1:0]       pwm_l;
  logic                  sync_out;

  pspwm_multich_core #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .enable   (enable),
    .period   (period),
    .duty     (duty),
    .phase    (phase),
    .deadtime (deadtime),
    .load_req (load_req),
    .load_ack (load_ack),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l),
    .sync_out (sync_out)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] h;
    logic [N_CH-1:0] l;
    logic            sync;
    logic            ack;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   done        = 0;

  // ---------------- reference model ----------------
  // Active configuration and carrier position, stepped once per clock edge.
  int m_P, m_dt, m_cnt;
  int m_duty[N_CH];
  int m_ph[N_CH];
  bit m_pend;
  // Per-cycle history: ideal level per channel, carrier running, count==0, dead-time in use.
  bit [N_CH-1:0] i_hist [MAXC];
  bit            run_hist[MAXC];
  bit            c0_hist [MAXC];
  int            dt_hist [MAXC];
  int            last_stop;   // latest cycle with the carrier stopped (history before it reads as low)

  function automatic void model_reset();
    m_P = 0; m_dt = 0; m_cnt = 0; m_pend = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_duty[c] = 0;
      m_ph[c]   = 0;
    end
  endfunction

  // Ideal level of a channel at the current carrier count (carrier assumed running).
  function automatic bit m_ideal(int c);
    int ph;
    ph = (m_ph[c] < m_P - 1) ? m_ph[c] : m_P - 1;
    return ((m_cnt + ph) % m_P) < m_duty[c];
  endfunction

  initial begin : model
    int k;
    bit rst_e, en_e, lr_e, run, wrap, cp, run_now;
    int per_e, dt_e;
    logic [N_CH*CNT_W-1:0] duty_e, ph_e;
    bit [N_CH-1:0] ib;
    exp_t e;
    k = 0;
    last_stop = 0;
    model_reset();
    forever begin
      @(posedge ACLK);
      rst_e = ARESET; en_e = enable; lr_e = load_req;
      per_e = int'(period); dt_e = int'(deadtime); duty_e = duty; ph_e = phase;
      if (!rst_e && k < MAXC) begin
        run  = en_e && (m_P >= 2);
        wrap = run && (m_cnt == m_P - 1);
        cp   = m_pend && (wrap || !run);
        for (int c = 0; c < N_CH; c++) ib[c] = run && m_ideal(c);
        i_hist[k] = ib; run_hist[k] = run; c0_hist[k] = (m_cnt == 0); dt_hist[k] = m_dt;
        if (!run) last_stop = k;
        m_cnt = run ? (wrap ? 0 : m_cnt + 1) : 0;
        if (cp) begin
          m_P = per_e; m_dt = dt_e;
          for (int c = 0; c < N_CH; c++) begin
            m_duty[c] = int'(duty_e[c*CNT_W +: CNT_W]);
            m_ph[c]   = int'(ph_e[c*CNT_W +: CNT_W]);
          end
        end
        m_pend = cp ? 1'b0 : (m_pend || lr_e);
      end
      k++;
      #2;
      e.cyc = k; e.h = '0; e.l = '0; e.sync = 1'b0; e.ack = 1'b0;
      if (k < MAXC) begin
        if (ARESET) begin
          model_reset();
          i_hist[k] = '0; run_hist[k] = 0; c0_hist[k] = 0; dt_hist[k] = 0;
          last_stop = k;
        end else begin
          run_now = enable && (m_P >= 2);
          e.ack = m_pend && (!run_now || (m_cnt == m_P - 1));
          if (k >= 2 && run_hist[k-1]) begin
            for (int c = 0; c < N_CH; c++) begin
              bit all1, all0;
              all1 = 1; all0 = 1;
              // High side needs the ideal level high for d+1 consecutive samples, low side low.
              for (int j = 0; j <= dt_hist[k-1]; j++) begin
                int idx;
                bit v;
                idx = k - 2 - j;
                v = (idx < 0 || idx <= last_stop) ? 1'b0 : i_hist[idx][c];
                if (v) all0 = 0; else all1 = 0;
              end
              e.h[c] = all1;
              e.l[c] = all0;
            end
          end
          if (k >= 3) e.sync = run_hist[k-2] && c0_hist[k-2] && run_hist[k-1];
        end
      end
      sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (done) break;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at t=%0t: no expected entry for DUT outputs", $time);
      end else begin
        e = sb_q.pop_front();
        if (pwm_h !== e.h || pwm_l !== e.l || sync_out !== e.sync || load_ack !== e.ack) begin
          miscompares++;
          $display("FAIL outputs cyc%0d: got h=%b l=%b sync=%b ack=%b, expected h=%b l=%b sync=%b ack=%b",
                   e.cyc, pwm_h, pwm_l, sync_out, load_ack, e.h, e.l, e.sync, e.ack);
        end
        vectors++;
        if ((pwm_h & pwm_l) !== '0) begin
          miscompares++;
          $display("FAIL gate_overlap cyc%0d: got h&l=%b, expected 0000", e.cyc, pwm_h & pwm_l);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic set_cfg(input int p, input int d0, input int d1, input int d2, input int d3,
                         input int p0, input int p1, input int p2, input int p3, input int dt);
    period   = CNT_W'(p);
    duty     = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    phase    = {CNT_W'(p3), CNT_W'(p2), CNT_W'(p1), CNT_W'(p0)};
    deadtime = DT_W'(dt);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
  endtask

  initial begin : driver
    int p, n;
    int d[N_CH];
    int ph[N_CH];
    int dt;
    ARESET = 1'b1; enable = 1'b0; load_req = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(3);
    ARESET = 1'b0;
    tick(4);
    enable = 1'b1;
    tick(5);                                   // active period 0: stays idle
    set_cfg(10, 5, 5, 5, 5, 0, 0, 0, 0, 0);    // exact complements
    pulse_load(); tick(40);
    set_cfg(10, 5, 5, 5, 5, 0, 0, 0, 0, 2);    // dead-time 2
    pulse_load(); tick(40);
    set_cfg(8, 4, 4, 4, 4, 0, 2, 4, 9, 0);     // phase shifts, 9 clamps to 7
    pulse_load(); tick(40);
    set_cfg(10, 0, 12, 2, 7, 0, 3, 5, 1, 3);   // duty extremes, pulse shorter than dead-time
    pulse_load(); tick(40);
    set_cfg(10, 5, 5, 5, 5, 0, 0, 0, 0, 1);
    pulse_load(); tick(13);
    set_cfg(20, 10, 10, 10, 10, 0, 5, 10, 15, 1); // mid-period reload, repeated request
    pulse_load(); tick(2); pulse_load(); tick(60);
    enable = 1'b0; tick(3); enable = 1'b1; tick(25);
    enable = 1'b0; tick(1); enable = 1'b1; tick(20);
    enable = 1'b0; set_cfg(12, 6, 3, 9, 1, 0, 1, 2, 3, 2);
    pulse_load(); tick(3); enable = 1'b1; tick(30);
    ARESET = 1'b1; tick(2); ARESET = 1'b0;     // reset mid-run
    tick(15);                                  // idle until a reload
    pulse_load(); tick(30);
    for (int s = 0; s < 40; s++) begin
      p  = $urandom_range(0, 24);
      dt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
      for (int c = 0; c < N_CH; c++) begin
        d[c]  = $urandom_range(0, p + 3);
        ph[c] = $urandom_range(0, p + 3);
      end
      set_cfg(p, d[0], d[1], d[2], d[3], ph[0], ph[1], ph[2], ph[3], dt);
      enable = ($urandom_range(0, 9) != 0);
      pulse_load();
      n = $urandom_range(5, 70);
      for (int t = 0; t < n; t++) begin
        load_req = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 49) == 0) enable = !enable;
        ARESET = ($urandom_range(0, 299) == 0);
        tick(1);
        ARESET = 1'b0;
      end
      load_req = 1'b0;
      enable = 1'b1;
    end
    tick(3);
    done = 1'b1;
    @(negedge ACLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
